// File: rtl/fp32_add_pipe.sv
// Four-stage pipelined IEEE-754 single-precision adder (denormals flushed to zero).
// Optional macro FP_ROUND_NEAREST_EN selects round-to-nearest-even; default build truncates.
module fp32_add_pipe #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  output logic [31:0] Sum,
  output logic        done
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Leading-zero count of a 27-bit mantissa; 27 when the input is all zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end else begin
        n     = n;
      end
    end
    return n;
  endfunction

  // ---------------- stage 1 signals ----------------
  logic [7:0]  exp_a_s, exp_b_s, exp_l_s, exp_x_s, diff_s;
  logic [30:0] mag_a_s, mag_b_s;
  logic        a_big_s, sign_l_s, sign_x_s;
  logic [23:0] mant_a_s, mant_b_s, mant_l_s, mant_x_s;
  logic [26:0] small_s, mask_s, aligned_s;
  logic        nan_a_s, nan_b_s, inf_a_s, inf_b_s, special_s;
  logic [31:0] spval_s;

  logic        s1_valid_r, s1_sign_l_r, s1_sign_x_r, s1_special_r;
  logic [7:0]  s1_exp_r;
  logic [26:0] s1_mant_l_r, s1_mant_x_r;
  logic [31:0] s1_spval_r;

  // Unpack, flush denormals, order by magnitude and align the smaller operand.
  always_comb begin
    exp_a_s  = operand_1[30:23];
    exp_b_s  = operand_2[30:23];
    mag_a_s  = (exp_a_s == 8'h00) ? 31'h0 : operand_1[30:0];
    mag_b_s  = (exp_b_s == 8'h00) ? 31'h0 : operand_2[30:0];
    mant_a_s = (exp_a_s == 8'h00) ? 24'h0 : {1'b1, operand_1[22:0]};
    mant_b_s = (exp_b_s == 8'h00) ? 24'h0 : {1'b1, operand_2[22:0]};
    a_big_s  = (mag_a_s >= mag_b_s);
    if (a_big_s) begin
      sign_l_s = operand_1[31];
      exp_l_s  = exp_a_s;
      mant_l_s = mant_a_s;
      sign_x_s = operand_2[31];
      exp_x_s  = exp_b_s;
      mant_x_s = mant_b_s;
    end else begin
      sign_l_s = operand_2[31];
      exp_l_s  = exp_b_s;
      mant_l_s = mant_b_s;
      sign_x_s = operand_1[31];
      exp_x_s  = exp_a_s;
      mant_x_s = mant_a_s;
    end
    diff_s  = exp_l_s - exp_x_s;
    small_s = {mant_x_s, 3'b000};
    mask_s  = ~(27'h7FF_FFFF << diff_s[4:0]);
    if (diff_s >= 8'd27) begin
      aligned_s = {26'h0, |small_s};
    end else begin
      aligned_s = (small_s >> diff_s[4:0]) | {26'h0, |(small_s & mask_s)};
    end

    nan_a_s = (exp_a_s == 8'hFF) && (operand_1[22:0] != 23'h0);
    nan_b_s = (exp_b_s == 8'hFF) && (operand_2[22:0] != 23'h0);
    inf_a_s = (exp_a_s == 8'hFF) && (operand_1[22:0] == 23'h0);
    inf_b_s = (exp_b_s == 8'hFF) && (operand_2[22:0] == 23'h0);
    if (nan_a_s || nan_b_s) begin
      special_s = 1'b1;
      spval_s   = QNAN;
    end else if (inf_a_s && inf_b_s && (operand_1[31] != operand_2[31])) begin
      special_s = 1'b1;
      spval_s   = QNAN;
    end else if (inf_a_s) begin
      special_s = 1'b1;
      spval_s   = operand_1;
    end else if (inf_b_s) begin
      special_s = 1'b1;
      spval_s   = operand_2;
    end else begin
      special_s = 1'b0;
      spval_s   = 32'h0;
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r   <= 1'b0;
      s1_sign_l_r  <= 1'b0;
      s1_sign_x_r  <= 1'b0;
      s1_special_r <= 1'b0;
      s1_exp_r     <= 8'h0;
      s1_mant_l_r  <= 27'h0;
      s1_mant_x_r  <= 27'h0;
      s1_spval_r   <= 32'h0;
    end else begin
      s1_valid_r   <= valid_in;
      s1_sign_l_r  <= sign_l_s;
      s1_sign_x_r  <= sign_x_s;
      s1_special_r <= special_s;
      s1_exp_r     <= exp_l_s;
      s1_mant_l_r  <= {mant_l_s, 3'b000};
      s1_mant_x_r  <= aligned_s;
      s1_spval_r   <= spval_s;
    end
  end

  // ---------------- stage 2: add / subtract ----------------
  logic        eff_sub_s;
  logic [27:0] sum_s;
  logic        s2_valid_r, s2_sign_r, s2_zsign_r, s2_special_r;
  logic [27:0] s2_sum_r;
  logic [7:0]  s2_exp_r;
  logic [31:0] s2_spval_r;

  // Larger minus smaller can never go negative since operands are magnitude-ordered.
  always_comb begin
    eff_sub_s = s1_sign_l_r ^ s1_sign_x_r;
    if (eff_sub_s) begin
      sum_s = {1'b0, s1_mant_l_r} - {1'b0, s1_mant_x_r};
    end else begin
      sum_s = {1'b0, s1_mant_l_r} + {1'b0, s1_mant_x_r};
    end
  end

  // Stage 2 register; a zero result from cancellation is +0, from adding zeros keeps the sign.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_r   <= 1'b0;
      s2_sign_r    <= 1'b0;
      s2_zsign_r   <= 1'b0;
      s2_special_r <= 1'b0;
      s2_sum_r     <= 28'h0;
      s2_exp_r     <= 8'h0;
      s2_spval_r   <= 32'h0;
    end else begin
      s2_valid_r   <= s1_valid_r;
      s2_sign_r    <= s1_sign_l_r;
      s2_zsign_r   <= eff_sub_s ? 1'b0 : s1_sign_l_r;
      s2_special_r <= s1_special_r;
      s2_sum_r     <= sum_s;
      s2_exp_r     <= s1_exp_r;
      s2_spval_r   <= s1_spval_r;
    end
  end

  // ---------------- stage 3: normalise ----------------
  logic [4:0]  lz_s;
  logic [26:0] n_mant_s;
  logic [9:0]  n_exp_s;
  logic        n_zero_s, n_sign_s;
  logic        s3_valid_r, s3_sign_r, s3_zero_r, s3_special_r;
  logic [26:0] s3_mant_r;
  logic [9:0]  s3_exp_r;
  logic [31:0] s3_spval_r;

  // Bring the leading one to bit 26; exponent underflow flushes to signed zero.
  always_comb begin
    lz_s     = lzc27(s2_sum_r[26:0]);
    n_mant_s = 27'h0;
    n_exp_s  = 10'h0;
    n_zero_s = 1'b0;
    n_sign_s = s2_sign_r;
    if (s2_sum_r[27]) begin
      n_mant_s = {s2_sum_r[27:2], s2_sum_r[1] | s2_sum_r[0]};
      n_exp_s  = {2'b00, s2_exp_r} + 10'd1;
    end else if (s2_sum_r == 28'h0) begin
      n_zero_s = 1'b1;
      n_sign_s = s2_zsign_r;
    end else begin
      n_mant_s = s2_sum_r[26:0] << lz_s;
      n_exp_s  = {2'b00, s2_exp_r} - {5'h00, lz_s};
      if (n_exp_s[9] || (n_exp_s == 10'h0)) begin
        n_zero_s = 1'b1;
      end else begin
        n_zero_s = 1'b0;
      end
    end
  end

  // Stage 3 register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s3_valid_r   <= 1'b0;
      s3_sign_r    <= 1'b0;
      s3_zero_r    <= 1'b0;
      s3_special_r <= 1'b0;
      s3_mant_r    <= 27'h0;
      s3_exp_r     <= 10'h0;
      s3_spval_r   <= 32'h0;
    end else begin
      s3_valid_r   <= s2_valid_r;
      s3_sign_r    <= n_sign_s;
      s3_zero_r    <= n_zero_s;
      s3_special_r <= s2_special_r;
      s3_mant_r    <= n_mant_s;
      s3_exp_r     <= n_exp_s;
      s3_spval_r   <= s2_spval_r;
    end
  end

  // ---------------- stage 4: round / pack ----------------
  logic        round_up_s;
  logic [24:0] rounded_s;
  logic [9:0]  r_exp_s;
  logic [22:0] r_frac_s;
  logic [31:0] result_s;

  // Round, renormalise on mantissa overflow, saturate to infinity, select specials.
  always_comb begin
`ifdef FP_ROUND_NEAREST_EN
    round_up_s = s3_mant_r[2] & (s3_mant_r[1] | s3_mant_r[0] | s3_mant_r[3]);
`else
    round_up_s = 1'b0;
`endif
    rounded_s = {1'b0, s3_mant_r[26:3]} + {24'h0, round_up_s};
    if (rounded_s[24]) begin
      r_exp_s  = s3_exp_r + 10'd1;
      r_frac_s = rounded_s[23:1];
    end else begin
      r_exp_s  = s3_exp_r;
      r_frac_s = rounded_s[22:0];
    end
    if (s3_special_r) begin
      result_s = s3_spval_r;
    end else if (s3_zero_r) begin
      result_s = {s3_sign_r, 31'h0};
    end else if (r_exp_s >= 10'd255) begin
      result_s = {s3_sign_r, 8'hFF, 23'h0};
    end else begin
      result_s = {s3_sign_r, r_exp_s[7:0], r_frac_s};
    end
  end

  // Output register; Sum only changes when a result is delivered.
  always_ff @(posedge clk) begin
    if (reset) begin
      Sum  <= 32'h0;
      done <= 1'b0;
    end else begin
      done <= s3_valid_r;
      if (s3_valid_r) begin
        Sum <= result_s;
      end else begin
        Sum <= Sum;
      end
    end
  end

endmodule

// File: tb/tb_fp32_add_pipe.sv
// Scoreboard bench for fp32_add_pipe: directed vectors with hand-computed sums.
module tb_fp32_add_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] operand_1 = 32'h0;
  logic [31:0] operand_2 = 32'h0;
  logic [31:0] Sum;
  logic        done;

  fp32_add_pipe #(.LATENCY(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .Sum       (Sum),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] val;
    int          cyc;
    int          id;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        chk_reset = 1'b0;
  logic        chk_hold = 1'b0;
  logic [31:0] hold_val = 32'h0;
  logic        timeout_flag = 1'b0;

  localparam int NV = 15;
  logic [31:0] va[NV];
  logic [31:0] vb[NV];
  logic [31:0] vs[NV];

  initial begin
    va[0]  = 32'h3FE00000; vb[0]  = 32'h415A0000; vs[0]  = 32'h41760000;
    va[1]  = 32'h3F180000; vb[1]  = 32'h415A0000; vs[1]  = 32'h41638000;
    va[2]  = 32'h40400000; vb[2]  = 32'hC0400000; vs[2]  = 32'h00000000;
    va[3]  = 32'h7F800000; vb[3]  = 32'hFF800000; vs[3]  = 32'h7FC00000;
    va[4]  = 32'h7F7FFFFF; vb[4]  = 32'h7F7FFFFF; vs[4]  = 32'h7F800000;
    va[5]  = 32'h3F800000; vb[5]  = 32'h33800000; vs[5]  = 32'h3F800000;
`ifdef FP_ROUND_NEAREST_EN
    va[6]  = 32'h3F800001; vb[6]  = 32'h33800000; vs[6]  = 32'h3F800002;
    va[14] = 32'h41200000; vb[14] = 32'h3DCCCCCD; vs[14] = 32'h4121999A;
`else
    va[6]  = 32'h3F800001; vb[6]  = 32'h33800000; vs[6]  = 32'h3F800001;
    va[14] = 32'h41200000; vb[14] = 32'h3DCCCCCD; vs[14] = 32'h41219999;
`endif
    va[7]  = 32'h00000000; vb[7]  = 32'h40490FDB; vs[7]  = 32'h40490FDB;
    va[8]  = 32'h00000001; vb[8]  = 32'h3F800000; vs[8]  = 32'h3F800000;
    va[9]  = 32'h7F800001; vb[9]  = 32'h3F800000; vs[9]  = 32'h7FC00000;
    va[10] = 32'hFF800000; vb[10] = 32'h3F800000; vs[10] = 32'hFF800000;
    va[11] = 32'h3F800000; vb[11] = 32'hBF400000; vs[11] = 32'h3E800000;
    va[12] = 32'h00800000; vb[12] = 32'h80800001; vs[12] = 32'h80000000;
    va[13] = 32'hC0400000; vb[13] = 32'h40400000; vs[13] = 32'h00000000;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every done and runs the quiet-window checks.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_done: done=1 Sum=%08h with nothing outstanding (cycle %0d)", Sum, cyc);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (Sum !== e.val) begin
          n_fail++;
          $display("FAIL sum_vec%0d: got %08h expected %08h", e.id, Sum, e.val);
        end
        n_cmp++;
        if (cyc != e.cyc + 4) begin
          n_fail++;
          $display("FAIL latency_vec%0d: done at cycle %0d expected cycle %0d", e.id, cyc, e.cyc + 4);
        end
      end
    end
    if (chk_reset) begin
      n_cmp++;
      if (Sum !== 32'h0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: Sum=%08h done=%b expected 00000000/0", Sum, done);
      end
    end
    if (chk_hold) begin
      n_cmp++;
      if (Sum !== hold_val || done !== 1'b0) begin
        n_fail++;
        $display("FAIL sum_hold: Sum=%08h done=%b expected %08h/0", Sum, done, hold_val);
      end
    end
    if (timeout_flag) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d results never arrived", exp_q.size());
      exp_q.delete();
    end
  end

  task automatic issue(input int idx);
    exp_t e;
    @(posedge clk); #1;
    valid_in  = 1'b1;
    operand_1 = va[idx];
    operand_2 = vb[idx];
    e.val = vs[idx];
    e.cyc = cyc;
    e.id  = idx;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    if (exp_q.size() != 0) begin
      timeout_flag = 1'b1;
      @(posedge clk); #1;
      timeout_flag = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);
    chk_reset = 1'b0;

    // Two back-to-back pairs, a gap, then the rest back-to-back.
    issue(0);
    issue(1);
    idle(3);
    for (int i = 2; i < NV; i++) issue(i);
    idle(1);
    drain();

    hold_val = vs[NV-1];
    chk_hold = 1'b1;
    idle(3);
    chk_hold = 1'b0;

    // In-flight operation killed by reset: no done, Sum cleared.
    @(posedge clk); #1;
    valid_in  = 1'b1;
    operand_1 = 32'h3FE00000;
    operand_2 = 32'h415A0000;
    @(posedge clk); #1;
    valid_in = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    chk_reset = 1'b1;
    idle(6);
    chk_reset = 1'b0;

    issue(4);
    idle(1);
    drain();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
